// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between instruction memory and the core fetch input
//
// Issues sequential word fetches (one outstanding at a time), buffers returned
// instructions with their PCs in a circular FIFO, and presents them to the core
// over a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   imem_addr         fetch address (word aligned), stable while stalled
//   imem_valid        fetch request valid
//   imem_ready        memory accepts the request this cycle
//   imem_done         one-cycle response strobe, imem_data holds the word
//   imem_data         returned instruction word
//   out_valid         head entry valid
//   out_ready         core consumes the head entry this cycle
//   out_pc, out_instr PC and instruction of the head entry
//   redirect          flush and restart fetch at redirect_pc
//   redirect_pc       new fetch PC, bits [1:0] ignored
//   empty             FIFO holds no entries (in-flight request not counted)

module fetch_queue #(
    parameter int               Width   = 32,
    parameter int               Depth   = 4,
    parameter logic [Width-1:0] ResetPc = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [Width-1:0] imem_addr,
    output logic             imem_valid,
    input  logic             imem_ready,
    input  logic             imem_done,
    input  logic [Width-1:0] imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_pc,
    output logic [Width-1:0] out_instr,
    input  logic             redirect,
    input  logic [Width-1:0] redirect_pc,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] fetch_pc;
    logic [Width-1:0] req_pc;
    logic             inflight;
    logic             discard;

    logic [PtrW-1:0]  head;
    logic [PtrW-1:0]  tail;
    logic [CntW-1:0]  count;

    logic [Width-1:0] pc_mem    [Depth];
    logic [Width-1:0] instr_mem [Depth];

    logic             resp;
    logic             push;
    logic             pop;
    logic             accept;
    logic [CntW-1:0]  reserved;

    // A response is only meaningful while a request is outstanding; a stray
    // done with nothing in flight is ignored.
    assign resp = inflight && imem_done;

    // Redirect wins over everything: the returning word and any pop are dropped.
    assign push = resp && !discard && !redirect;
    assign pop  = (count != '0) && out_ready && !redirect;

    // The outstanding (non-discarded) request already owns a FIFO slot, even in
    // the cycle its data returns, so a new fetch is only issued if one more slot
    // beyond that is free. This keeps the FIFO from ever overflowing without
    // making imem_valid depend on out_ready.
    assign reserved = count + CntW'(inflight && !discard);

    assign imem_valid = !rst && !redirect && (!inflight || imem_done)
                        && (reserved < CntW'(Depth));
    assign imem_addr  = fetch_pc;
    assign accept     = imem_valid && imem_ready;

    assign out_valid = (count != '0);
    assign out_pc    = pc_mem[head];
    assign out_instr = instr_mem[head];
    assign empty     = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= ResetPc;
            req_pc   <= ResetPc;
            inflight <= 1'b0;
            discard  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= {redirect_pc[Width-1:2], 2'b00};
            if (resp) begin
                // The outstanding word returns now and is simply dropped.
                inflight <= 1'b0;
                discard  <= 1'b0;
            end else if (inflight) begin
                // The old request is still out; swallow its response later.
                discard  <= 1'b1;
            end
        end else begin
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + Width'(4);
                inflight <= 1'b1;
            end else if (resp) begin
                inflight <= 1'b0;
            end

            if (resp && discard) begin
                discard <= 1'b0;
            end

            if (push) begin
                tail <= tail + PtrW'(1);
            end
            if (pop) begin
                head <= head + PtrW'(1);
            end
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    // Entry storage carries no reset; out_valid guards every read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail]    <= req_pc;
            instr_mem[tail] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  imem_addr;
    logic          imem_valid;
    logic          imem_ready;
    logic          imem_done;
    logic [W-1:0]  imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_instr;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic          empty;

    fetch_queue #(.Width(W), .Depth(D), .ResetPc(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_ready(imem_ready),
        .imem_done(imem_done), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus knobs: mode 0 = always 1, 1 = always 0, 2 = random
    int          k_rdy, k_or, k_lat_min, k_lat_max, k_redir_pct;
    bit          k_force;
    logic [31:0] k_rpc;

    // reference model: memory with one pending response, expected PC streams
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] exp_fetch, exp_out;
    int          outstanding;
    int          n_acc, n_pop;
    bit          st_prev;
    logic [31:0] st_addr;

    // observations of the most recent cycle
    logic        o_ivalid, o_ovalid, o_empty, o_done, o_acc, o_pop, o_rd, o_ordy;
    logic [31:0] o_addr, o_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        pend        = 1'b0;
        pend_cnt    = 0;
        exp_fetch   = RPC;
        exp_out     = RPC;
        outstanding = 0;
        n_acc       = 0;
        n_pop       = 0;
        st_prev     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0; imem_done = 1'b0; imem_data = '0;
        out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // One clock: drive at negedge, sample #1 later, score, then cross posedge.
    task automatic cycle();
        bit          rdy, ordy, rd, dn, acc, pp;
        logic [31:0] rp, acc_addr;
        @(negedge clk);
        rdy  = (k_rdy == 0) ? 1'b1 : (k_rdy == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
        ordy = (k_or  == 0) ? 1'b1 : (k_or  == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
        rd   = k_force || (int'($urandom_range(0, 99)) < k_redir_pct);
        rp   = k_force ? k_rpc : $urandom;
        k_force = 1'b0;
        dn   = pend && (pend_cnt == 1);
        imem_ready  = rdy;
        out_ready   = ordy;
        redirect    = rd;
        redirect_pc = rp;
        imem_done   = dn;
        imem_data   = dn ? mem_word(pend_addr) : $urandom;
        #1;
        acc = imem_valid && rdy;
        pp  = out_valid && ordy && !rd;
        o_ivalid = imem_valid; o_ovalid = out_valid; o_empty = empty; o_done = dn;
        o_acc = acc; o_pop = pp; o_rd = rd; o_ordy = ordy; o_addr = imem_addr; o_pc = out_pc;

        if (rd) begin
            checks++;
            if (imem_valid !== 1'b0) begin
                errors++; $display("FAIL redirect_no_issue: imem_valid=%b required 0", imem_valid);
            end
        end
        if (st_prev && !rd) begin
            checks++;
            if (imem_valid !== 1'b1 || imem_addr !== st_addr) begin
                errors++;
                $display("FAIL stall_hold: valid=%b addr=%h required valid=1 addr=%h", imem_valid, imem_addr, st_addr);
            end
        end
        if (acc) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
                errors++; $display("FAIL accept_addr: got %h required %h", imem_addr, exp_fetch);
            end
            checks++;
            if (pend && !dn) begin
                errors++; $display("FAIL single_outstanding: accept at %h while %h pending", imem_addr, pend_addr);
            end
        end
        if (pp) begin
            checks++;
            if (out_pc !== exp_out) begin
                errors++; $display("FAIL out_pc: got %h required %h", out_pc, exp_out);
            end
            checks++;
            if (out_instr !== mem_word(exp_out)) begin
                errors++; $display("FAIL out_instr: got %h required %h", out_instr, mem_word(exp_out));
            end
        end

        st_prev  = imem_valid && !rdy && !rd;
        st_addr  = imem_addr;
        acc_addr = imem_addr;
        if (acc) begin exp_fetch += 4; outstanding++; n_acc++; end
        if (pp)  begin exp_out   += 4; outstanding--; n_pop++; end
        if (rd)  begin exp_fetch = rp & ~32'h3; exp_out = rp & ~32'h3; outstanding = 0; end
        checks++;
        if (outstanding > D) begin
            errors++; $display("FAIL occupancy: got %0d required <= %0d", outstanding, D);
        end

        @(posedge clk);
        if (pend) begin
            if (dn) pend = 1'b0;
            else    pend_cnt--;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = int'($urandom_range(k_lat_min, k_lat_max));
        end
    endtask

    task automatic set_knobs(input int rdy, input int ordy, input int lmin, input int lmax, input int rp);
        k_rdy = rdy; k_or = ordy; k_lat_min = lmin; k_lat_max = lmax; k_redir_pct = rp; k_force = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b0; imem_done = 1'b0; imem_data = '0;
        out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL reset_imem_valid: got %b required 0", imem_valid); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
        checks++; if (imem_addr !== RPC)   begin errors++; $display("FAIL reset_addr: got %h required %h", imem_addr, RPC); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (imem_valid !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL post_reset_issue: valid=%b addr=%h required 1 %h", imem_valid, imem_addr, RPC);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        set_knobs(0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (o_ovalid !== (i >= 2)) begin
                errors++; $display("FAIL stream_valid[%0d]: got %b required %b", i, o_ovalid, (i >= 2));
            end
            if (i == 2) begin
                checks++;
                if (o_pc !== RPC) begin errors++; $display("FAIL stream_first_pc: got %h required %h", o_pc, RPC); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        do_reset();
        set_knobs(0, 1, 1, 1, 0);
        repeat (10) cycle();
        checks++; if (n_acc != D)          begin errors++; $display("FAIL full_accepts: got %0d required %0d", n_acc, D); end
        checks++; if (o_ivalid !== 1'b0)   begin errors++; $display("FAIL full_imem_valid: got %b required 0", o_ivalid); end
        checks++; if (o_addr !== 32'h110)  begin errors++; $display("FAIL full_addr: got %h required 00000110", o_addr); end
        checks++; if (o_ovalid !== 1'b1 || o_empty !== 1'b0) begin
            errors++; $display("FAIL full_out: valid=%b empty=%b required 1 0", o_ovalid, o_empty);
        end
        k_or = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (o_acc && !seen) begin
                seen = 1'b1;
                checks++;
                if (o_addr !== 32'h110) begin errors++; $display("FAIL resume_addr: got %h required 00000110", o_addr); end
            end
        end
        checks++; if (!seen || n_pop < D) begin errors++; $display("FAIL drain: resumed=%b pops=%0d required 1 >=%0d", seen, n_pop, D); end
    endtask

    task automatic test_stall();
        do_reset();
        set_knobs(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (o_ivalid !== 1'b1 || o_addr !== RPC) begin
                errors++; $display("FAIL stall[%0d]: valid=%b addr=%h required 1 %h", i, o_ivalid, o_addr, RPC);
            end
        end
        k_rdy = 0;
        repeat (10) cycle();
        checks++; if (n_pop != 8) begin errors++; $display("FAIL stall_pops: got %0d required 8", n_pop); end
    endtask

    task automatic test_redirect_inflight();
        bit got;
        do_reset();
        set_knobs(0, 0, 1, 1, 0);
        for (int i = 0; i < 20 && exp_fetch != 32'h108; i++) cycle();
        k_lat_min = 3; k_lat_max = 3;
        cycle();
        checks++; if (!o_acc || o_addr !== 32'h108) begin errors++; $display("FAIL rd_setup: acc=%b addr=%h required 1 00000108", o_acc, o_addr); end
        k_lat_min = 1; k_lat_max = 1;
        k_force = 1'b1; k_rpc = 32'h2002;
        cycle();
        cycle();
        checks++;
        if (o_ivalid !== 1'b0 || o_ovalid !== 1'b0 || o_empty !== 1'b1) begin
            errors++; $display("FAIL rd_wait: ivalid=%b ovalid=%b empty=%b required 0 0 1", o_ivalid, o_ovalid, o_empty);
        end
        cycle();
        checks++; if (!o_done || !o_acc || o_addr !== 32'h2000) begin
            errors++; $display("FAIL rd_restart: done=%b acc=%b addr=%h required 1 1 00002000", o_done, o_acc, o_addr);
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (o_pop) begin
                got = 1'b1;
                checks++;
                if (o_pc !== 32'h2000) begin errors++; $display("FAIL rd_first_pc: got %h required 00002000", o_pc); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rd_timeout: no output within budget"); end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        set_knobs(0, 0, 1, 1, 0);
        repeat (5) cycle();
        k_force = 1'b1; k_rpc = 32'h2003;
        cycle();
        checks++;
        if (!(o_done && o_ovalid && o_ordy && o_rd)) begin
            errors++; $display("FAIL coinc_setup: done=%b ovalid=%b ordy=%b rd=%b required all 1", o_done, o_ovalid, o_ordy, o_rd);
        end
        cycle();
        checks++;
        if (o_ivalid !== 1'b1 || o_addr !== 32'h2000 || o_ovalid !== 1'b0 || o_empty !== 1'b1) begin
            errors++;
            $display("FAIL coinc_after: ivalid=%b addr=%h ovalid=%b empty=%b required 1 00002000 0 1", o_ivalid, o_addr, o_ovalid, o_empty);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_knobs(0, 0, 1, 1, 0);
        repeat (6) cycle();
        checks++; if (o_ovalid !== 1'b1) begin errors++; $display("FAIL areset_pre: out_valid=%b required 1", o_ovalid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_valid !== 1'b0 || out_valid !== 1'b0 || empty !== 1'b1 || imem_addr !== RPC) begin
            errors++;
            $display("FAIL areset_now: ivalid=%b ovalid=%b empty=%b addr=%h required 0 0 1 %h", imem_valid, out_valid, empty, imem_addr, RPC);
        end
        do_reset();
        cycle();
        checks++; if (!o_acc || o_addr !== RPC) begin errors++; $display("FAIL areset_first: acc=%b addr=%h required 1 %h", o_acc, o_addr, RPC); end
    endtask

    task automatic test_random();
        do_reset();
        set_knobs(2, 2, 1, 4, 4);
        repeat (3000) cycle();
        checks++; if (n_pop < 100) begin errors++; $display("FAIL random_progress: pops=%0d required >= 100", n_pop); end
    endtask

    initial begin
        set_knobs(0, 0, 1, 1, 0);
        k_rpc = '0;
        model_clear();
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_redirect_inflight();
        test_redirect_coincident();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
